// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: hunts for SOF, buffers a length-prefixed frame and releases verified payloads.
// Optional trailing checksum byte is compiled in by defining UART_DEFRAMER_CHECKSUM_EN.
module uart_rx_deframer #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [7:0]    MAX_L    = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [1:0]    ERR_LEN  = 2'b01;
  localparam logic [1:0]    ERR_TMO  = 2'b11;

`ifdef UART_DEFRAMER_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_EMIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_EMIT} state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_len, w_len_nxt;
  logic [7:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_rd, w_rd_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]    r_out_data, w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_out_last, w_out_last_nxt;
  logic          r_pkt_done, w_pkt_done_nxt;
  logic          r_pkt_err, w_pkt_err_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_in_ready, w_in_ready_nxt;
`ifdef UART_DEFRAMER_CHECKSUM_EN
  logic [7:0]    r_sum, w_sum_nxt;
`endif

  logic [7:0] r_buf [MAX_LEN];

  logic w_accept;
  logic w_buf_we;
  logic w_go_emit;
  logic w_in_frame;

  assign w_accept = in_valid && r_in_ready;

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign pkt_done  = r_pkt_done;
  assign pkt_err   = r_pkt_err;
  assign err_code  = r_err_code;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_rd_nxt        = r_rd;
    w_tmo_nxt       = r_tmo;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_pkt_done_nxt  = 1'b0;
    w_pkt_err_nxt   = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_buf_we        = 1'b0;
    w_go_emit       = 1'b0;
    w_in_frame      = 1'b0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
    w_sum_nxt       = r_sum;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept && (in_data == SOF)) begin
          w_state_nxt = S_LEN;
          w_tmo_nxt   = '0;
        end
      end

      S_LEN: begin
        w_in_frame = 1'b1;
        if (w_accept) begin
          if ((in_data == 8'd0) || (in_data > MAX_L)) begin
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = ERR_LEN;
            w_state_nxt    = S_IDLE;
          end else begin
            w_len_nxt   = in_data;
            w_idx_nxt   = 8'd0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
            w_sum_nxt   = in_data;
`endif
            w_state_nxt = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        w_in_frame = 1'b1;
        if (w_accept) begin
          w_buf_we  = 1'b1;
          w_idx_nxt = r_idx + 8'd1;
`ifdef UART_DEFRAMER_CHECKSUM_EN
          w_sum_nxt = r_sum + in_data;
          if ((r_idx + 8'd1) == r_len) w_state_nxt = S_CSUM;
`else
          if ((r_idx + 8'd1) == r_len) w_go_emit = 1'b1;
`endif
        end
      end

`ifdef UART_DEFRAMER_CHECKSUM_EN
      S_CSUM: begin
        w_in_frame = 1'b1;
        if (w_accept) begin
          if (8'(r_sum + in_data) == 8'd0) begin
            w_go_emit = 1'b1;
          end else begin
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = ERR_CSUM;
            w_state_nxt    = S_IDLE;
          end
        end
      end
`endif

      S_EMIT: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_pkt_done_nxt  = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_rd_nxt       = r_rd + 8'd1;
            w_out_data_nxt = r_buf[IW'(r_rd + 8'd1)];
            w_out_last_nxt = ((r_rd + 8'd2) == r_len);
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // First payload byte may still be on in_data when a 1-byte frame completes
    if (w_go_emit) begin
      w_state_nxt     = S_EMIT;
      w_rd_nxt        = 8'd0;
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = (r_len == 8'd1);
      w_out_data_nxt  = ((r_state == S_PAYLOAD) && (r_idx == 8'd0)) ? in_data : r_buf[0];
    end

    // Inter-byte timeout; saturates on the hit and the frame is abandoned
    if ((TIMEOUT_CYC != 0) && w_in_frame) begin
      if (w_accept) begin
        w_tmo_nxt = '0;
      end else if (r_tmo == TMO_LAST) begin
        w_tmo_nxt      = TMO_MAX;
        w_pkt_err_nxt  = 1'b1;
        w_err_code_nxt = ERR_TMO;
        w_state_nxt    = S_IDLE;
      end else begin
        w_tmo_nxt = r_tmo + TW'(1);
      end
    end

    w_in_ready_nxt = (w_state_nxt != S_EMIT);
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_rd        <= 8'd0;
      r_tmo       <= '0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= 2'b00;
      r_in_ready  <= 1'b1;
`ifdef UART_DEFRAMER_CHECKSUM_EN
      r_sum       <= 8'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_rd        <= w_rd_nxt;
      r_tmo       <= w_tmo_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
      r_pkt_err   <= w_pkt_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_in_ready  <= w_in_ready_nxt;
`ifdef UART_DEFRAMER_CHECKSUM_EN
      r_sum       <= w_sum_nxt;
`endif
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge sys_clk) begin
    if (w_buf_we) r_buf[IW'(r_idx)] <= in_data;
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: scoreboarded payload stream plus error/timeout/reset checks.
// Frame format follows UART_DEFRAMER_CHECKSUM_EN like the design.
module tb_uart_rx_deframer;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 50;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_err_seen  = 0;
  int n_done_seen = 0;
  int e_err  = 0;
  int e_done = 0;
  int t_acc;
  int n_wait;

  logic [8:0] sb [$];
  logic [7:0] pl [$];
  logic       stall_q   = 1'b0;
  logic       last_hs_q = 1'b0;
  logic [7:0] hold_data = 8'd0;
  logic       hold_last = 1'b0;

  uart_rx_deframer #(
    .MAX_LEN    (MAX_LEN),
    .SOF        (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .err_code (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, pkt_done alignment, in_ready during EMIT
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      stall_q   = 1'b0;
      last_hs_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (pkt_done || last_hs_q) check("pkt_done_align", 32'(pkt_done), 32'(last_hs_q));
      if (pkt_err) n_err_seen++;
      if (pkt_done) n_done_seen++;
      if (out_valid) check("in_ready_emit", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          logic [8:0] exp_b;
          exp_b = sb.pop_front();
          check("out_byte", 32'({out_last, out_data}), 32'(exp_b));
        end
      end
      last_hs_q = out_valid && out_ready && out_last;
      stall_q   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge sys_clk);
    while (!in_ready && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 400) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends SOF, length, payload from pl (and checksum) and pushes the expected output
  task automatic send_frame();
    logic       lst;
`ifdef UART_DEFRAMER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'(pl.size());
    foreach (pl[i]) s = s + pl[i];
`endif
    foreach (pl[i]) begin
      lst = (i == pl.size() - 1);
      sb.push_back({lst, pl[i]});
    end
    send_byte(8'hA5);
    send_byte(8'(pl.size()));
    foreach (pl[i]) send_byte(pl[i]);
`ifdef UART_DEFRAMER_CHECKSUM_EN
    send_byte(8'd0 - s);
`endif
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Good 3-byte frame, first byte presented the cycle after the final frame byte
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame();
    check("emit_lat_valid", 32'(out_valid), 32'd1);
    check("emit_lat_data", 32'(out_data), 32'h11);
    check("emit_lat_in_ready", 32'(in_ready), 32'd0);
    wait_drain();
    e_done++;
    check("done_pulse", 32'(pkt_done), 32'd1);
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
    @(posedge sys_clk); #1;
    check("done_pulse_end", 32'(pkt_done), 32'd0);
    check("done_count", 32'(n_done_seen), 32'(e_done));
    check("ok_err_code", 32'(err_code), 32'd0);
    check("ok_err_count", 32'(n_err_seen), 32'(e_err));

`ifdef UART_DEFRAMER_CHECKSUM_EN
    // Wrong checksum byte
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h98);
    e_err++;
    check("csum_pkt_err", 32'(pkt_err), 32'd1);
    check("csum_err_code", 32'(err_code), 32'd2);
    check("csum_in_ready", 32'(in_ready), 32'd1);
    check("csum_out_valid", 32'(out_valid), 32'd0);
    @(posedge sys_clk); #1;
`endif

    // Garbage before SOF, then zero and oversize lengths
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_no_err", 32'(pkt_err), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h00);
    e_err++;
    check("len0_pkt_err", 32'(pkt_err), 32'd1);
    check("len0_err_code", 32'(err_code), 32'd1);
    @(posedge sys_clk); #1;
    check("len0_pulse_end", 32'(pkt_err), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    e_err++;
    check("len17_pkt_err", 32'(pkt_err), 32'd1);
    check("len17_err_code", 32'(err_code), 32'd1);
    @(posedge sys_clk); #1;
    check("len_err_count", 32'(n_err_seen), 32'(e_err));

    // Stalled frame times out TMO cycles after the last accepted byte
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    t_acc  = cyc;
    n_wait = 0;
    while (!pkt_err && n_wait < 200) begin
      @(negedge sys_clk);
      n_wait++;
    end
    check("tmo_delay", 32'(cyc - t_acc), 32'(TMO));
    check("tmo_err_code", 32'(err_code), 32'd3);
    e_err++;
    @(posedge sys_clk); #1;
    pl = '{8'h5A};
    send_frame();
    check("len1_data", 32'({out_last, out_data}), 32'h15A);
    wait_drain();
    e_done++;
    @(posedge sys_clk); #1;
    check("tmo_err_count", 32'(n_err_seen), 32'(e_err));
    check("tmo_done_count", 32'(n_done_seen), 32'(e_done));

    // Full-length frame with SOF value inside the payload and a 1,0,0 out_ready pattern
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h40 + 8'(i * 3)));
    pl[5] = 8'hA5;
    send_frame();
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      out_ready = (k % 3 == 0);
      @(posedge sys_clk); #1;
    end
    out_ready = 1'b1;
    check("toggle_drain", 32'(sb.size()), 32'd0);
    e_done++;
    @(posedge sys_clk); #1;
    check("toggle_done_count", 32'(n_done_seen), 32'(e_done));
    check("toggle_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of EMIT after two bytes have transferred
    pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    send_frame();
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    check("mid_rst_pkt_err", 32'(pkt_err), 32'd0);
    check("mid_rst_left", 32'(sb.size()), 32'd3);
    sb.delete();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame();
    wait_drain();
    e_done++;
    @(posedge sys_clk); #1;
    check("final_done_count", 32'(n_done_seen), 32'(e_done));
    check("final_err_count", 32'(n_err_seen), 32'(e_err));
    check("final_err_code", 32'(err_code), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
